// File: rtl/ms_es_mul_result_accum_if.sv
// Handshake bundle between the multiplier result accumulator and its upstream/downstream peers.
// master = the side that drives start/products/ready; slave = the accumulator itself.
interface ms_es_mul_result_accum_if #(
    parameter int WXIP1     = 10,
    parameter int NUM_TERMS = 4
);
    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int ACC_W = WXIP1 + $clog2(NUM_TERMS + 1);

    logic             start;
    logic             mul_en;
    logic [WXIP1-1:0] mul_data;
    logic             mul_done;
    logic [CNT_W-1:0] term_idx;
    logic [ACC_W-1:0] sum_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, mul_data, mul_done, out_ready,
        input  mul_en, term_idx, sum_out, out_valid, busy
    );

    modport slave (
        input  start, mul_data, mul_done, out_ready,
        output mul_en, term_idx, sum_out, out_valid, busy
    );
endinterface

// File: rtl/ms_es_mul_result_accum.sv
// Accumulates NUM_TERMS multiplier products into a dot product and holds the multiplier
// stalled until the finished sum is taken on the valid/ready output.
module ms_es_mul_result_accum #(
    parameter int WXIP1     = 10,
    parameter int NUM_TERMS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ms_es_mul_result_accum_if.slave   bus
);
    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam int ACC_W = WXIP1 + $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] term_idx_q;
    logic [ACC_W-1:0] sum_q;

    // Width ACC_W holds NUM_TERMS full-scale products, so this never wraps.
    assign acc_d = acc_q + ACC_W'(bus.mul_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            term_idx_q <= '0;
            sum_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= RUN;
                        acc_q      <= '0;
                        term_idx_q <= '0;
                    end
                end
                RUN: begin
                    if (bus.mul_done) begin
                        acc_q <= acc_d;
                        if (term_idx_q == LAST_IDX) begin
                            sum_q      <= acc_d;
                            term_idx_q <= '0;
                            state_q    <= HOLD;
                        end else begin
                            term_idx_q <= term_idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // start seen in the accepting cycle is dropped; it must be re-issued in IDLE.
                    if (bus.out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mul_en    = (state_q == RUN);
    assign bus.busy      = (state_q == RUN) || (state_q == HOLD);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.term_idx  = term_idx_q;
    assign bus.sum_out   = sum_q;
endmodule

// File: tb/tb_ms_es_mul_result_accum.sv
// Directed + randomized checks of the dot-product accumulator against a plain-arithmetic model.
module tb_ms_es_mul_result_accum;
    localparam int WXIP1     = 10;
    localparam int NUM_TERMS = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ms_es_mul_result_accum_if #(.WXIP1(WXIP1), .NUM_TERMS(NUM_TERMS)) bus ();

    ms_es_mul_result_accum #(.WXIP1(WXIP1), .NUM_TERMS(NUM_TERMS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_mulen"}, 32'(bus.mul_en), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_idx"},   32'(bus.term_idx), 0);
    endtask

    // Reference: the dot product is simply the arithmetic sum of the products.
    function automatic int model_sum(input int p[NUM_TERMS]);
        int s = 0;
        for (int i = 0; i < NUM_TERMS; i++) s += p[i];
        return s;
    endfunction

    // Runs one dot product and leaves the DUT in HOLD (unless out_ready was already high).
    task automatic run_terms(input string tag, input int p[NUM_TERMS], input bit spur);
        int exp_sum = model_sum(p);
        if (spur) begin
            bus.mul_done = 1'b1; bus.mul_data = 10'd500;
            tick();
            bus.mul_done = 1'b0;
            chk({tag, "_idle_done"}, 32'(bus.busy), 0);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({tag, "_run_en"}, 32'(bus.mul_en), 1);
        for (int i = 0; i < NUM_TERMS; i++) begin
            int gap = $urandom_range(3, 19);
            for (int g = 0; g < gap; g++) begin
                bus.start = spur && (g == 1);
                tick();
            end
            bus.start = 1'b0;
            chk($sformatf("%s_idx%0d", tag, i), 32'(bus.term_idx), i);
            bus.mul_data = WXIP1'(p[i]);
            bus.mul_done = 1'b1;
            tick();
            bus.mul_done = 1'b0;
            bus.mul_data = '0;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_sum"},   32'(bus.sum_out), exp_sum);
        chk({tag, "_hold_en"}, 32'(bus.mul_en), 0);
        chk({tag, "_hold_idx"}, 32'(bus.term_idx), 0);
    endtask

    // Backpressure for bp cycles, then accept; optionally start/mul_done noise while held.
    task automatic accept(input string tag, input int bp, input int exp_sum, input bit noise);
        bus.out_ready = 1'b0;
        for (int c = 0; c < bp; c++) begin
            bus.mul_done = noise && (c == 2);
            bus.mul_data = 10'd77;
            tick();
            bus.mul_done = 1'b0;
        end
        chk({tag, "_bp_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_bp_sum"},   32'(bus.sum_out), exp_sum);
        chk({tag, "_bp_en"},    32'(bus.mul_en), 0);
        bus.out_ready = 1'b1;
        bus.start     = noise;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk_idle({tag, "_acc"});
        tick();
        chk({tag, "_stay_idle"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int p[NUM_TERMS];
        rst = 1'b0;
        bus.start = 1'b0; bus.mul_done = 1'b0; bus.mul_data = '0; bus.out_ready = 1'b0;
        tick();

        rst = 1'b1; bus.start = 1'b1; bus.mul_done = 1'b1; bus.mul_data = 10'h3ff;
        tick(); tick();
        chk_idle("reset");
        chk("reset_sum", 32'(bus.sum_out), 0);
        rst = 1'b0; bus.start = 1'b0; bus.mul_done = 1'b0;
        tick();
        chk_idle("reset_post");

        p = '{3, 5, 7, 9};
        run_terms("basic", p, 1'b0);
        accept("basic", 10, 24, 1'b0);

        p = '{1023, 1023, 1023, 1023};
        run_terms("maxval", p, 1'b0);
        accept("maxval", 1, 4092, 1'b0);

        p = '{11, 22, 33, 44};
        run_terms("spur", p, 1'b1);
        accept("spur", 5, 110, 1'b1);

        // Reset in the middle of a run discards the partial sum.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.mul_data = 10'd200; bus.mul_done = 1'b1; tick(); bus.mul_done = 1'b0;
        end
        chk("midrst_idx", 32'(bus.term_idx), 2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_idle("midrst");
        chk("midrst_sum", 32'(bus.sum_out), 0);
        p = '{1, 1, 1, 1};
        run_terms("after_rst", p, 1'b0);
        accept("after_rst", 3, 4, 1'b0);

        // Random products, out_ready already high before out_valid rises.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_TERMS; i++) p[i] = int'($urandom_range(0, 1023));
            bus.out_ready = (r % 2 == 0);
            run_terms($sformatf("rnd%0d", r), p, r[0]);
            if (bus.out_ready) begin
                tick();
                bus.out_ready = 1'b0;
                chk_idle($sformatf("rnd%0d_early", r));
            end else begin
                accept($sformatf("rnd%0d", r), $urandom_range(1, 6), model_sum(p), 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
